uart_rx_fifo: RTL and testbench

Receive-side byte buffer between the uart core (rx_data/rx_done) and the io register block.
- Captures every received byte on the rising edge of rx_done.
- Holds received bytes in a first-word-fall-through FIFO, so the CPU can poll and drain them without losing back-to-back bytes at 115200 baud.
- io exposes dout/status as memory-mapped reads and drives pop/clear from CPU writes.

---
 rtl/uart_rx_fifo_pkg.sv | 27 ++
 rtl/uart_rx_fifo_mem.sv | 24 ++
 rtl/uart_rx_fifo.sv | 95 +++++++++
 tb/tb_uart_rx_fifo.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the uart receive FIFO and its io register view.
package uart_rx_fifo_pkg;

  localparam int UART_FIFO_DEPTH_BITS = 4;

  // io register map for the receive FIFO
  localparam logic [7:0] IO_UART_FIFO_DATA   = 8'h30;
  localparam logic [7:0] IO_UART_FIFO_STATUS = 8'h31;
  localparam logic [7:0] IO_UART_FIFO_CTRL   = 8'h32;

  // status register bit positions
  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 3;
  localparam int ST_CNT_MAX = 31;

  // Pack flags and count into the io status byte; count saturates at 31
  // so deeper FIFOs still fit the 5-bit field.
  function automatic logic [7:0] status_word(input logic empty, input logic full,
                                             input logic ovf, input int unsigned cnt);
    logic [4:0] c;
    c = (cnt > ST_CNT_MAX) ? 5'(ST_CNT_MAX) : 5'(cnt);
    return {c, ovf, full, empty};
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Register-array storage for the receive FIFO: synchronous write, async read.
// Kept separate so it can be swapped for a block RAM later.
module uart_rx_fifo_mem #(
  parameter int DEPTH_BITS = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_BITS-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_BITS];

  // Write port; contents need no reset since reads are gated by count.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO between the uart core and the io block.
// Edge-detects rx_done, buffers bytes, tracks count and a sticky overflow.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_BITS = UART_FIFO_DEPTH_BITS,
  parameter int DATA_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_done,
  input  logic                pop,
  input  logic                clear,
  output logic [DATA_W-1:0]   dout,
  output logic [DEPTH_BITS:0] count,
  output logic                empty,
  output logic                full,
  output logic                overflow
);

  localparam int                  DEPTH   = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] CNT_MAX = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] CNT_ONE = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  rx_done_q;
  logic                  ovf_q, ovf_d;
  logic                  push_req, do_push, do_pop;
  logic [DATA_W-1:0]     rdata;

  assign push_req = rx_done & ~rx_done_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_MAX);
  // Pop only acts on a visible head; a full FIFO accepts a push if the
  // same cycle frees a slot.
  assign do_pop   = pop & ~empty & ~clear;
  assign do_push  = push_req & (~full | pop) & ~clear;

  // Next-state for pointers, count and sticky overflow; clear wins.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop) count_d = count_q + CNT_ONE;
      if (do_pop && !do_push) count_d = count_q - CNT_ONE;
      if (push_req && full && !pop) ovf_d = 1'b1;
    end
  end

  // State registers; rx_done_q tracks every cycle, including during clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      rx_done_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      rx_done_q <= rx_done;
      ovf_q     <= ovf_d;
    end
  end

  uart_rx_fifo_mem #(
    .DEPTH_BITS(DEPTH_BITS),
    .DATA_W    (DATA_W)
  ) u_mem (
    .clk  (clk),
    .we   (do_push),
    .waddr(wr_ptr_q),
    .wdata(rx_data),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );

  assign dout     = empty ? '0 : rdata;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a random run
// checked against a queue-based reference model.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done, pop, clear;
  logic [7:0] dout;
  logic [4:0] count;
  logic       empty, full, overflow;

  int vecs = 0;
  int errs = 0;

  // reference model state
  logic [7:0] mq[$];
  logic       m_rdq;
  logic       m_ovf;

  uart_rx_fifo #(.DEPTH_BITS(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .pop(pop), .clear(clear), .dout(dout), .count(count),
    .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_rdq = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic rd, input logic [7:0] d, input logic p, input logic c);
    logic pr, pv;
    rx_done = rd; rx_data = d; pop = p; clear = c;
    @(posedge clk);
    pr = rd & ~m_rdq;
    m_rdq = rd;
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      pv = p && (mq.size() > 0);
      if (pv) void'(mq.pop_front());
      if (pr) begin
        if (mq.size() < 16) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic pulse(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_done = 0; rx_data = 0; pop = 0; clear = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %b want 1", empty); end
    vecs++; if (full !== 1'b0) begin errs++; $display("FAIL reset_full got %b want 0", full); end
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL reset_count got %0d want 0", count); end
    vecs++; if (dout !== 8'h00) begin errs++; $display("FAIL reset_dout got %h want 00", dout); end
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL reset_ovf got %b want 0", overflow); end
  endtask

  task automatic test_held_level();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h41, 1'b0, 1'b0);
      vecs++; if (count !== 5'd1) begin errs++; $display("FAIL held_count cyc%0d got %0d want 1", i, count); end
      vecs++; if (dout !== 8'h41) begin errs++; $display("FAIL held_dout cyc%0d got %h want 41", i, dout); end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL held_pop_empty got %b want 1", empty); end
    vecs++; if (dout !== 8'h00) begin errs++; $display("FAIL held_pop_dout got %h want 00", dout); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) pulse(8'(i));
    vecs++; if (full !== 1'b1) begin errs++; $display("FAIL fill_full got %b want 1", full); end
    vecs++; if (count !== 5'd16) begin errs++; $display("FAIL fill_count got %0d want 16", count); end
    pulse(8'hAA);
    vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_flag got %b want 1", overflow); end
    vecs++; if (count !== 5'd16) begin errs++; $display("FAIL ovf_count got %0d want 16", count); end
    for (int i = 0; i < 16; i++) begin
      vecs++; if (dout !== 8'(i)) begin errs++; $display("FAIL drain_dout idx%0d got %h want %h", i, dout, 8'(i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL drain_empty got %b want 1", empty); end
    vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) pulse(8'h10 + 8'(i));
    step(1'b1, 8'h55, 1'b1, 1'b0);
    vecs++; if (count !== 5'd16) begin errs++; $display("FAIL fpp_count got %0d want 16", count); end
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL fpp_ovf got %b want 0", overflow); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] want;
      want = (i == 15) ? 8'h55 : 8'h11 + 8'(i);
      vecs++; if (dout !== want) begin errs++; $display("FAIL wrap_dout idx%0d got %h want %h", i, dout, want); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL wrap_empty got %b want 1", empty); end
  endtask

  task automatic test_empty_push_pop();
    step(1'b1, 8'h33, 1'b1, 1'b0);
    vecs++; if (count !== 5'd1) begin errs++; $display("FAIL epp_count got %0d want 1", count); end
    vecs++; if (dout !== 8'h33) begin errs++; $display("FAIL epp_dout got %h want 33", dout); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL underflow_count got %0d want 0", count); end
    vecs++; if (dout !== 8'h00) begin errs++; $display("FAIL underflow_dout got %h want 00", dout); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 17; i++) pulse(8'h80 + 8'(i));
    for (int i = 0; i < 13; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    vecs++; if (count !== 5'd3 || overflow !== 1'b1) begin errs++;
      $display("FAIL preclear got cnt=%0d ovf=%b want cnt=3 ovf=1", count, overflow); end
    step(1'b1, 8'h77, 1'b0, 1'b1);
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL clear_count got %0d want 0", count); end
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL clear_ovf got %b want 0", overflow); end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL clear_empty got %b want 1", empty); end
    step(1'b1, 8'h77, 1'b0, 1'b0);
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL clear_held_count got %0d want 0", count); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    pulse(8'hC1); pulse(8'hC2);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || dout !== 8'h00 || overflow !== 1'b0) begin
      errs++; $display("FAIL async_reset got e=%b f=%b c=%0d d=%h o=%b want e=1 f=0 c=0 d=00 o=0",
                       empty, full, count, dout, overflow); end
    model_reset();
    rx_done = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic rd, p, c;
      logic [7:0] d, wd;
      rd = ($urandom_range(0, 99) < 55);
      p  = ($urandom_range(0, 99) < ((n % 200) < 100 ? 20 : 60));
      c  = ($urandom_range(0, 99) < 2);
      d  = 8'($urandom);
      step(rd, d, p, c);
      wd = (mq.size() > 0) ? mq[0] : 8'h00;
      vecs++; if (count !== 5'(mq.size()) || dout !== wd || overflow !== m_ovf ||
                  empty !== (mq.size() == 0) || full !== (mq.size() == 16)) begin
        errs++;
        $display("FAIL random cyc%0d got c=%0d d=%h o=%b e=%b f=%b want c=%0d d=%h o=%b",
                 n, count, dout, overflow, empty, full, mq.size(), wd, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_held_level();
    test_fill_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
